// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between the UART receiver core and a consumer.
// Converts receiver byte/error strobes into a Depth-entry byte FIFO with a valid/ready
// output, keeps overrun and error-count status, and pulses idle after a quiet period.
// Ports:
//   clk, nReset          clock, asynchronous active-low reset
//   rxData, rxDone       received byte and its completion strobe (rising edge = 1 byte)
//   rxErr                receiver error strobe (rising edge = 1 error event)
//   outData, outValid    FIFO head byte and non-empty flag
//   outReady             consumer accepts head when outValid && outReady
//   level                FIFO occupancy
//   overrun              sticky flag: a byte was dropped on a full FIFO
//   errCount             saturating error event count
//   idle                 one-cycle pulse after IdleCycles quiet cycles following a byte
//   clearStatus          synchronous clear of overrun and errCount
module uart_rx_ctrl #(
  parameter int unsigned Depth      = 4,
  parameter int unsigned IdleCycles = 2560
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic [7:0]               outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(Depth):0]   level,
  output logic                     overrun,
  output logic [7:0]               errCount,
  output logic                     idle,
  input  logic                     clearStatus
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(IdleCycles);

  typedef enum logic {WAIT, CAPTURE} state_t;

  state_t          state, stateNext;
  logic            push;
  logic            doneQ, errQ;
  logic            doneRise, errRise;
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [7:0]      mem [Depth];
  logic            full, pop, pushOk, drop;
  logic [PW-1:0]   levelNext;
  logic [TW-1:0]   timer, timerNext;
  logic            armed, armSrc, fire;

  assign doneRise = rxDone & ~doneQ;
  assign errRise  = rxErr & ~errQ;

  // Strobe edge-detect registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
    end else begin
      doneQ <= rxDone;
      errQ  <= rxErr;
    end
  end

  // Capture FSM state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= WAIT;
    else         state <= stateNext;
  end

  // Capture FSM: one CAPTURE cycle per rxDone rising edge issues the push
  always_comb begin
    stateNext = state;
    push      = 1'b0;
    case (state)
      WAIT:    if (doneRise) stateNext = CAPTURE;
      CAPTURE: begin
        push      = 1'b1;
        stateNext = WAIT;
      end
      default: stateNext = WAIT;
    endcase
  end

  // FIFO control; a push into a full FIFO is still accepted when a pop frees the slot
  always_comb begin
    full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    pop    = outValid && outReady;
    pushOk = push && (!full || pop);
    drop   = push && full && !pop;
    levelNext = level;
    case ({pushOk, pop})
      2'b10:   levelNext = level + PW'(1);
      2'b01:   levelNext = level - PW'(1);
      default: levelNext = level;
    endcase
  end

  assign outData = mem[rdPtr[AW-1:0]];

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      outValid <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= 8'h00;
    end else begin
      if (pushOk) begin
        mem[wrPtr[AW-1:0]] <= rxData;
        wrPtr              <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      level    <= levelNext;
      outValid <= (levelNext != '0);
    end
  end

  // Status: a coinciding event overrides clearStatus
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      overrun  <= 1'b0;
      errCount <= 8'h00;
    end else begin
      if (drop)             overrun <= 1'b1;
      else if (clearStatus) overrun <= 1'b0;

      if (clearStatus)      errCount <= errRise ? 8'h01 : 8'h00;
      else if (errRise && errCount != 8'hFF) errCount <= errCount + 8'h01;
    end
  end

  // Idle timer: the push cycle counts as zero, so the pulse lands IdleCycles-1 cycles later
  always_comb begin
    armSrc    = push || armed;
    timerNext = push ? TW'(1) : timer + TW'(1);
    fire      = armSrc && (timerNext == TW'(IdleCycles - 1));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      timer <= '0;
      armed <= 1'b0;
      idle  <= 1'b0;
    end else begin
      if (armSrc) timer <= timerNext;
      armed <= armSrc && !fire;
      idle  <= fire;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bytes into a queue,
// a monitor pops and compares on each accepted output transfer.
module tb_uart_rx_ctrl;

  localparam int unsigned Depth      = 4;
  localparam int unsigned IdleCycles = 16;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [2:0] level;
  logic       overrun;
  logic [7:0] errCount;
  logic       idle;
  logic       clearStatus;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [7:0] expQ [$];

  uart_rx_ctrl #(.Depth(Depth), .IdleCycles(IdleCycles)) dut (
    .clk(clk), .nReset(nReset), .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
    .outData(outData), .outValid(outValid), .outReady(outReady), .level(level),
    .overrun(overrun), .errCount(errCount), .idle(idle), .clearStatus(clearStatus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every accepted head byte against the scoreboard
  always @(negedge clk) begin
    if (nReset && outValid && outReady) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL pop_unexpected: got %0h expected none", outData);
      end else begin
        check("pop_data", 32'(outData), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int hold);
    tick();
    rxData = b;
    rxDone = 1'b1;
    repeat (hold) tick();
    rxDone = 1'b0;
    repeat (2) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    outReady = 1'b1;
    while (level != 3'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(level), 32'd0);
    tick();
    outReady = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int firstIdle;
    int idleHits;
    nReset = 1'b0; rxData = 8'h00; rxDone = 1'b0; rxErr = 1'b0;
    outReady = 1'b0; clearStatus = 1'b0;
    #22;
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_outData",  32'(outData),  32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_overrun",  32'(overrun),  32'd0);
    check("rst_errCount", 32'(errCount), 32'd0);
    check("rst_idle",     32'(idle),     32'd0);
    tick();
    nReset = 1'b1;
    tick();

    // Single byte with rxDone held 3 cycles; outValid two cycles after the rise
    rxData = 8'hA5; rxDone = 1'b1;
    expQ.push_back(8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("lat_capture_outValid", 32'(outValid), 32'd0);
    @(negedge clk);
    check("lat_outValid", 32'(outValid), 32'd1);
    check("lat_outData",  32'(outData),  32'hA5);
    check("lat_level",    32'(level),    32'd1);
    tick();
    rxDone = 1'b0;
    repeat (2) tick();
    check("one_byte_level", 32'(level), 32'd1);
    drain();

    // Fill beyond Depth: fifth byte dropped, overrun set
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expQ.push_back(8'(i));
      sendByte(8'(i), 2);
    end
    check("fill_level",   32'(level),   32'd4);
    check("fill_overrun", 32'(overrun), 32'd1);
    drain();
    tick();
    clearStatus = 1'b1;
    tick();
    clearStatus = 1'b0;
    @(negedge clk);
    check("clear_overrun", 32'(overrun), 32'd0);

    // Full FIFO with a pop in the push cycle: no overrun, 0x77 comes out last
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(8'h11 + 8'(i));
      sendByte(8'h11 + 8'(i), 1);
    end
    check("full_level", 32'(level), 32'd4);
    tick();
    rxData = 8'h77; rxDone = 1'b1;
    expQ.push_back(8'h77);
    tick();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    tick();
    rxDone = 1'b0;
    @(negedge clk);
    check("simul_overrun", 32'(overrun), 32'd0);
    check("simul_level",   32'(level),   32'd4);
    drain();

    // Error counting with saturation and clear/event coincidence
    for (int i = 0; i < 300; i++) begin
      tick(); rxErr = 1'b1;
      tick(); rxErr = 1'b0;
      if (i == 2) begin
        @(negedge clk);
        check("err_three", 32'(errCount), 32'd3);
      end
    end
    @(negedge clk);
    check("err_saturate", 32'(errCount), 32'd255);
    tick();
    rxErr = 1'b1; clearStatus = 1'b1;
    tick();
    rxErr = 1'b0; clearStatus = 1'b0;
    @(negedge clk);
    check("err_clear_coincide", 32'(errCount), 32'd1);
    check("err_no_push", 32'(level), 32'd0);

    // Idle: let earlier timers expire, then one byte and silence
    repeat (3 * IdleCycles) tick();
    outReady = 1'b1;
    rxData = 8'h3C; rxDone = 1'b1;
    expQ.push_back(8'h3C);
    firstIdle = -1;
    idleHits  = 0;
    for (int k = 1; k <= 3 * int'(IdleCycles); k++) begin
      @(negedge clk);
      if (k == 3) rxDone = 1'b0;
      if (idle) begin
        idleHits++;
        if (firstIdle < 0) firstIdle = k;
      end
    end
    check("idle_position", 32'(firstIdle), 32'(IdleCycles + 1));
    check("idle_count",    32'(idleHits),  32'd1);
    tick();
    outReady = 1'b0;

    // Async reset with full FIFO and overrun set
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expQ.push_back(8'hC1 + 8'(i));
      sendByte(8'hC1 + 8'(i), 1);
    end
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    @(negedge clk);
    #1;
    nReset = 1'b0;
    #1;
    check("async_outValid", 32'(outValid), 32'd0);
    check("async_level",    32'(level),    32'd0);
    check("async_overrun",  32'(overrun),  32'd0);
    check("async_outData",  32'(outData),  32'd0);
    expQ.delete();
    tick();
    nReset = 1'b1;
    repeat (2) tick();
    check("post_rst_outValid", 32'(outValid), 32'd0);
    check("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
